// File: rtl/mii_rx_framer.sv
// mii_rx_framer: MII receive front end. Strips preamble/SFD, pairs nibbles
// into bytes (low nibble first), marks first/last bytes and reports
// per-frame length and {oversize, runt, crc, phy_align} status on the last byte.
module mii_rx_framer #(
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518,
   parameter int unsigned LEN_W   = 11
) (
   input  logic             eth_rx_clk,
   input  logic             reset,
   input  logic             eth_rx_dv,
   input  logic [3:0]       eth_rxd,
   input  logic             eth_rxerr,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_first,
   output logic             out_last,
   output logic [LEN_W-1:0] out_len,
   output logic [3:0]       out_err
);

   typedef enum logic [1:0] {WAIT_IDLE, HUNT, DATA, DISCARD} state_t;

   localparam logic [LEN_W-1:0] MIN_CNT     = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAX_CNT     = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] ONE_CNT     = LEN_W'(1);
   localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;

   state_t           state;
   logic [3:0]       prev_nib;
   logic [3:0]       low_nib;
   logic             phase;
   logic [7:0]       hold;
   logic             hold_full;
   logic [LEN_W-1:0] count;
   logic [31:0]      crc;
   logic             align_err;
   logic [7:0]       new_byte;

   // Reflected CRC-32 update for one byte, LSB first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   assign new_byte = {eth_rxd, low_nib};

   // Framing FSM. A completed byte is held for one byte time so that the
   // byte preceding a dv drop (or the MAX_LEN overflow) can carry out_last.
   always_ff @(posedge eth_rx_clk or posedge reset) begin
      if (reset) begin
         state     <= WAIT_IDLE;
         prev_nib  <= '0;
         low_nib   <= '0;
         phase     <= 1'b0;
         hold      <= '0;
         hold_full <= 1'b0;
         count     <= '0;
         crc       <= '1;
         align_err <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_len   <= '0;
         out_err   <= '0;
      end else begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         case (state)
            WAIT_IDLE: begin
               if (!eth_rx_dv) begin
                  prev_nib <= '0;
                  state    <= HUNT;
               end
            end
            HUNT: begin
               if (eth_rx_dv) begin
                  prev_nib <= eth_rxd;
                  if (prev_nib == 4'h5 && eth_rxd == 4'hD) begin
                     phase     <= 1'b0;
                     count     <= '0;
                     crc       <= '1;
                     align_err <= 1'b0;
                     hold_full <= 1'b0;
                     state     <= DATA;
                  end
               end else begin
                  prev_nib <= '0;
               end
            end
            DATA: begin
               if (eth_rx_dv) begin
                  if (eth_rxerr) align_err <= 1'b1;
                  if (!phase) begin
                     low_nib <= eth_rxd;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (count == MAX_CNT) begin
                        out_valid <= 1'b1;
                        out_data  <= hold;
                        out_first <= (count == ONE_CNT);
                        out_last  <= 1'b1;
                        out_len   <= MAX_CNT;
                        out_err   <= {1'b1, 2'b00, align_err | eth_rxerr};
                        hold_full <= 1'b0;
                        state     <= DISCARD;
                     end else begin
                        if (hold_full) begin
                           out_valid <= 1'b1;
                           out_data  <= hold;
                           out_first <= (count == ONE_CNT);
                        end
                        hold      <= new_byte;
                        hold_full <= 1'b1;
                        crc       <= crc_byte(crc, new_byte);
                        count     <= count + ONE_CNT;
                     end
                  end
               end else begin
                  if (hold_full) begin
                     out_valid <= 1'b1;
                     out_data  <= hold;
                     out_first <= (count == ONE_CNT);
                     out_last  <= 1'b1;
                     out_len   <= count;
                     out_err   <= {1'b0, count < MIN_CNT, crc != CRC_RESIDUE, align_err | phase};
                  end
                  hold_full <= 1'b0;
                  prev_nib  <= '0;
                  state     <= HUNT;
               end
            end
            DISCARD: begin
               if (!eth_rx_dv) begin
                  prev_nib <= '0;
                  state    <= HUNT;
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mii_rx_framer.sv
// tb_mii_rx_framer: directed and randomized frames checked against a
// frame-level reference model (expected strobe list per frame).
module tb_mii_rx_framer;

   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int LEN_W   = 11;

   logic             eth_rx_clk = 1'b0;
   logic             reset;
   logic             eth_rx_dv;
   logic [3:0]       eth_rxd;
   logic             eth_rxerr;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_first;
   logic             out_last;
   logic [LEN_W-1:0] out_len;
   logic [3:0]       out_err;

   mii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .eth_rx_clk (eth_rx_clk),
      .reset      (reset),
      .eth_rx_dv  (eth_rx_dv),
      .eth_rxd    (eth_rxd),
      .eth_rxerr  (eth_rxerr),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_first  (out_first),
      .out_last   (out_last),
      .out_len    (out_len),
      .out_err    (out_err)
   );

   always #20 eth_rx_clk = ~eth_rx_clk;

   typedef struct packed {
      logic [7:0]       data;
      logic             first;
      logic             last;
      logic [LEN_W-1:0] len;
      logic [3:0]       err;
   } rec_t;

   rec_t       cap_q[$];
   rec_t       exp_q[$];
   logic [7:0] tx[$];
   logic [7:0] base[$];
   int         checks   = 0;
   int         failures = 0;
   int         orphans  = 0;

   // Capture every strobe away from the active edge.
   always @(negedge eth_rx_clk) begin
      rec_t r;
      if (out_valid) begin
         r.data  = out_data;
         r.first = out_first;
         r.last  = out_last;
         r.len   = out_len;
         r.err   = out_err;
         cap_q.push_back(r);
      end
      if (!out_valid && (out_first || out_last)) orphans++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Standard Ethernet FCS over tx[0..n-1].
   function automatic logic [31:0] fcs_of(input int n);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {24'h0, tx[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic make_frame(input int n_data, input bit with_da);
      logic [31:0] f;
      tx.delete();
      for (int i = 0; i < n_data; i++) tx.push_back(8'($urandom));
      if (with_da) begin
         tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56;
         tx[3] = 8'h78; tx[4] = 8'h9A; tx[5] = 8'hBC;
      end
      f = fcs_of(n_data);
      tx.push_back(f[7:0]);
      tx.push_back(f[15:8]);
      tx.push_back(f[23:16]);
      tx.push_back(f[31:24]);
   endtask

   // Reference model: expected strobes for the frame held in tx.
   task automatic expect_frame(input int err_at, input bit odd);
      int          n, l;
      bit          rxe, crc_bad;
      logic [31:0] fcs_rx;
      logic [3:0]  e;
      rec_t        r;
      n = tx.size();
      if (n == 0) return;
      l   = (n > MAX_LEN) ? MAX_LEN : n;
      rxe = (err_at >= 0) && (err_at < n) && (err_at <= MAX_LEN);
      if (n > MAX_LEN) begin
         e = {1'b1, 2'b00, rxe};
      end else begin
         if (n < 4) crc_bad = 1'b1;
         else begin
            fcs_rx  = {tx[n-1], tx[n-2], tx[n-3], tx[n-4]};
            crc_bad = (fcs_of(n - 4) != fcs_rx);
         end
         e = {1'b0, n < MIN_LEN, crc_bad, rxe | odd};
      end
      for (int i = 0; i < l; i++) begin
         r.data  = tx[i];
         r.first = (i == 0);
         r.last  = (i == l - 1);
         r.len   = (i == l - 1) ? LEN_W'(l) : '0;
         r.err   = (i == l - 1) ? e : '0;
         exp_q.push_back(r);
      end
   endtask

   task automatic drive_nib(input logic dv, input logic [3:0] d, input logic er);
      @(posedge eth_rx_clk);
      #2;
      eth_rx_dv = dv;
      eth_rxd   = d;
      eth_rxerr = er;
   endtask

   task automatic send_frame(input int err_at, input bit odd, input int idle, input int rst_rel_at);
      logic [7:0] b;
      for (int i = 0; i < 15; i++) drive_nib(1'b1, 4'h5, 1'b0);
      drive_nib(1'b1, 4'hD, 1'b0);
      for (int i = 0; i < tx.size(); i++) begin
         if (i == rst_rel_at) begin
            @(posedge eth_rx_clk);
            #5 reset = 1'b0;
         end
         b = tx[i];
         drive_nib(1'b1, b[3:0], 1'(i == err_at));
         drive_nib(1'b1, b[7:4], 1'b0);
      end
      if (odd) drive_nib(1'b1, 4'($urandom), 1'b0);
      for (int i = 0; i < idle; i++) drive_nib(1'b0, 4'h0, 1'b0);
   endtask

   task automatic compare_all(input string tag);
      int   n;
      rec_t c, e;
      repeat (3) @(posedge eth_rx_clk);
      @(negedge eth_rx_clk);
      check({tag, " count"}, 64'(cap_q.size()), 64'(exp_q.size()));
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int k = 0; k < n; k++) begin
         c = cap_q.pop_front();
         e = exp_q.pop_front();
         if (e.last) check({tag, " last"}, 64'(c), 64'(e));
         else check({tag, " byte"}, 64'({c.data, c.first, c.last}), 64'({e.data, e.first, e.last}));
      end
      cap_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int mode, len, pos;
      reset     = 1'b1;
      eth_rx_dv = 1'b0;
      eth_rxd   = 4'h0;
      eth_rxerr = 1'b0;
      repeat (3) @(posedge eth_rx_clk);
      @(negedge eth_rx_clk);
      check("reset outputs", 64'({out_valid, out_first, out_last, out_data, out_len, out_err}), 64'h0);
      @(posedge eth_rx_clk);
      #2 reset = 1'b0;
      repeat (2) drive_nib(1'b0, 4'h0, 1'b0);

      make_frame(60, 1'b1);
      base = tx;
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 4, -1);
      compare_all("good64");

      tx = base;
      tx[20] = tx[20] ^ 8'h01;
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 4, -1);
      compare_all("crc_flip");

      tx = base;
      expect_frame(30, 1'b0);
      send_frame(30, 1'b0, 4, -1);
      compare_all("rxerr");

      make_frame(36, 1'b0);
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 4, -1);
      compare_all("runt40");

      // Reset held into a frame and released while dv=1: frame is ignored.
      @(posedge eth_rx_clk);
      #2 reset = 1'b1;
      @(negedge eth_rx_clk);
      check("reset mid outputs", 64'({out_valid, out_first, out_last}), 64'h0);
      make_frame(60, 1'b1);
      send_frame(-1, 1'b0, 4, 10);
      compare_all("rst_release_mid");
      make_frame(60, 1'b1);
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 4, -1);
      compare_all("after_rst");

      tx.delete();
      for (int i = 0; i < 1600; i++) tx.push_back(8'($urandom));
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 4, -1);
      compare_all("oversize");
      make_frame(70, 1'b1);
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 4, -1);
      compare_all("after_oversize");

      make_frame(60, 1'b1);
      expect_frame(-1, 1'b0);
      send_frame(-1, 1'b0, 1, -1);
      make_frame(80, 1'b1);
      expect_frame(-1, 1'b1);
      send_frame(-1, 1'b1, 4, -1);
      compare_all("b2b_odd");

      tx.delete();
      send_frame(-1, 1'b0, 4, -1);
      compare_all("empty");

      for (int t = 0; t < 8; t++) begin
         mode = $urandom_range(3, 0);
         len  = (t < 2) ? $urandom_range(30, 5) : $urandom_range(200, 60);
         make_frame(len, 1'b0);
         pos = $urandom_range(tx.size() - 1, 0);
         if (mode == 1) tx[pos] = tx[pos] ^ (8'h01 << $urandom_range(7, 0));
         expect_frame((mode == 2) ? pos : -1, 1'(mode == 3));
         send_frame((mode == 2) ? pos : -1, 1'(mode == 3), $urandom_range(4, 1), -1);
         compare_all("random");
      end

      check("orphan first/last", 64'(orphans), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
